riscv_csr_arbiter: RTL and testbench
====================================

# riscv_csr_arbiter

Shares the single SRAM-like port of the control/status register file between the core pipeline (ID/EX CSR instructions) and the external debug unit. Core accesses pass through with zero added latency. Debug accesses are granted when the port is idle, when the core is halted, or after a bounded starvation wait, in which case the core is stalled for one cycle. The block sits between the decoder/EX stage, the debug unit, and the CSR file.

## Interface
- `DBG_MAX_WAIT`, default 8: cycles a pending debug request may be blocked by core CSR traffic before it is forced through. Legal range 1..255.
- `WAIT_BITS`, default `$clog2(DBG_MAX_WAIT+1)`: width of the starvation counter.

Ports:
- `clk`  in  1  core clock; single clock domain.
- `rst_n`  in  1  asynchronous active-low reset.
- `core_csr_access_i`  in  1  core CSR instruction in EX this cycle.
- `core_csr_addr_i`  in  12  core CSR address.
- `core_csr_wdata_i`  in  32  core write operand.
- `core_csr_op_i`  in  2  core CSR_OP_* code.
- `core_csr_rdata_o`  out  32  read data to core; combinational from `csr_rdata_i`.
- `core_stall_o`  out  1  core CSR access suppressed this cycle; core must re-present it.
- `dbg_req_i`  in  1  debug access request; held with stable fields until granted.
- `dbg_we_i`  in  1  1 = write, 0 = read.
- `dbg_addr_i`  in  12  debug CSR address.
- `dbg_wdata_i`  in  32  debug write data.
- `dbg_halted_i`  in  1  core halted by debug; the debug unit has priority.
- `exc_busy_i`  in  1  exception save/restore in progress; debug grant is deferred.
- `dbg_gnt_o`  out  1  debug request accepted this cycle (combinational).
- `dbg_rvalid_o`  out  1  response valid; registered, one cycle after grant.
- `dbg_rdata_o`  out  32  registered CSR value read in the grant cycle (pre-write value).
- `csr_access_o`, `csr_addr_o[11:0]`, `csr_wdata_o[31:0]`, `csr_op_o[1:0]`  out  to CSR file.
- `csr_rdata_i`  in  32  combinational read data from the CSR file.

## Operation
- States: IDLE and RESP, encoded as a local enum.
- **Grant condition** (valid only in IDLE): `dbg_gnt = dbg_req_i & ~exc_busy_i & (dbg_halted_i | ~core_csr_access_i | wait_cnt == DBG_MAX_WAIT)`.
- **Debug granted:**
  - CSR port is driven with the debug fields: `csr_access_o = 1`, `csr_op_o` = CSR_OP_WRITE if `dbg_we_i`, else CSR_OP_NONE.
  - `core_stall_o = core_csr_access_i`.
  - `dbg_rdata_o <= csr_rdata_i`, `wait_cnt <= 0`, next state RESP.
- **Not granted:**
  - CSR port carries the core fields.
  - If `core_csr_access_i = 0`, then `csr_access_o = 0` and `csr_op_o` is forced to CSR_OP_NONE. The CSR file decodes write enable from op alone, so this forcing is mandatory.
- **wait_cnt:**
  - Increments, saturating at `DBG_MAX_WAIT`, when `dbg_req_i` is high and the grant is blocked by core traffic or `exc_busy_i`.
  - Clears when `dbg_req_i = 0`.
- **RESP:** `dbg_rvalid_o = 1` for exactly one cycle; no debug grant is possible; core passes through. Next state is IDLE. Maximum debug throughput is one access per 2 cycles.
- `exc_busy_i` overrides starvation and halt. When the count saturates, the grant fires on the first cycle `exc_busy_i` is low.
- Exception saves in the CSR file still take priority over a simultaneous debug write to mstatus/mepc. This is acceptable because `exc_busy_i` covers the save window.

## Timing
- Core path: zero latency; purely combinational mux.
- Debug: `dbg_gnt_o` in cycle t; write takes effect at the t→t+1 edge; `dbg_rvalid_o`/`dbg_rdata_o` valid in cycle t+1.
- Worst-case debug latency with continuous core traffic and no `exc_busy_i`: DBG_MAX_WAIT+1 cycles from request to grant.
- Reset values: state IDLE, `wait_cnt = 0`, `dbg_rvalid_o = 0`, `dbg_rdata_o = 0`. Combinational outputs follow the inputs with IDLE state.
- Reset asserted mid-access: a pending RESP is dropped (no rvalid). The debug unit re-issues after reset.

## Structure
- CSR_OP_NONE/WRITE/SET/CLEAR come from `riscv_defines`.
- Add `DBG_CSR_MAX_WAIT` as the shared default constant in `riscv_defines`.
- State enum stays local to the module.
- Single module; no sub-module is warranted.

## Test plan
- Core-only: `core_csr_access_i = 1`, op SET, addr 0x300, wdata 1, `dbg_req_i = 0` → `csr_op_o` = SET, addr 0x300 in the same cycle; `core_stall_o = 0`.
- Idle debug read: `dbg_req_i = 1`, `dbg_we_i = 0`, addr 0x341, mepc = 0x1234, core idle → `dbg_gnt_o = 1` in cycle t; `dbg_rvalid_o = 1` with `dbg_rdata_o = 0x1234` in t+1; rvalid low in t+2.
- Starvation with `DBG_MAX_WAIT = 8`: core accesses every cycle, debug write to 0x7C0 with data 1 → grant exactly on the 9th request cycle; `core_stall_o = 1` that cycle only; mestatus reads 1 afterward.
- Halted priority: `dbg_halted_i = 1` with `core_csr_access_i = 1` → immediate grant and `core_stall_o = 1`.
- Exception block: `exc_busy_i = 1` for 12 cycles with a saturated counter → no grant; grant in the first cycle `exc_busy_i` goes low.
- Idle op forcing and reset: core idle with `core_csr_op_i` = WRITE → `csr_op_o` = NONE. `rst_n` low during RESP → `dbg_rvalid_o` goes 0 immediately and stays 0 after release.

Source files
------------

// File: rtl/riscv_defines.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | riscv_defines: shared CSR operation codes and arbiter defaults   |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
package riscv_defines;

  localparam logic [1:0] CSR_OP_NONE  = 2'b00;
  localparam logic [1:0] CSR_OP_WRITE = 2'b01;
  localparam logic [1:0] CSR_OP_SET   = 2'b10;
  localparam logic [1:0] CSR_OP_CLEAR = 2'b11;

  localparam int DBG_CSR_MAX_WAIT = 8;

endpackage
`default_nettype wire

// File: rtl/riscv_csr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | riscv_csr_arbiter: core/debug arbitration of the CSR file port   |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module riscv_csr_arbiter
  import riscv_defines::*;
#(
  parameter int DBG_MAX_WAIT = DBG_CSR_MAX_WAIT,
  parameter int WAIT_BITS    = $clog2(DBG_MAX_WAIT + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_csr_access_i,
  input  logic [11:0] core_csr_addr_i,
  input  logic [31:0] core_csr_wdata_i,
  input  logic [1:0]  core_csr_op_i,
  output logic [31:0] core_csr_rdata_o,
  output logic        core_stall_o,
  input  logic        dbg_req_i,
  input  logic        dbg_we_i,
  input  logic [11:0] dbg_addr_i,
  input  logic [31:0] dbg_wdata_i,
  input  logic        dbg_halted_i,
  input  logic        exc_busy_i,
  output logic        dbg_gnt_o,
  output logic        dbg_rvalid_o,
  output logic [31:0] dbg_rdata_o,
  output logic        csr_access_o,
  output logic [11:0] csr_addr_o,
  output logic [31:0] csr_wdata_o,
  output logic [1:0]  csr_op_o,
  input  logic [31:0] csr_rdata_i
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  state_e               r_state;
  state_e               w_state_nxt;
  logic [WAIT_BITS-1:0] r_wait_cnt;
  logic [WAIT_BITS-1:0] w_wait_nxt;
  logic                 w_wait_sat;
  logic                 w_gnt;
  logic                 r_rvalid;
  logic [31:0]          r_rdata;

  assign w_wait_sat = (r_wait_cnt == WAIT_BITS'(DBG_MAX_WAIT));

  always_comb begin
    w_state_nxt  = ST_IDLE;
    w_wait_nxt   = r_wait_cnt;
    w_gnt        = 1'b0;
    core_stall_o = 1'b0;
    csr_access_o = core_csr_access_i;
    csr_addr_o   = core_csr_addr_i;
    csr_wdata_o  = core_csr_wdata_i;
    // The CSR file decodes write enable from op alone, so an idle core must show NONE
    csr_op_o     = core_csr_access_i ? core_csr_op_i : CSR_OP_NONE;

    if (r_state == ST_IDLE) begin
      w_gnt = dbg_req_i & ~exc_busy_i &
              (dbg_halted_i | ~core_csr_access_i | w_wait_sat);
    end

    if (w_gnt) begin
      csr_access_o = 1'b1;
      csr_addr_o   = dbg_addr_i;
      csr_wdata_o  = dbg_wdata_i;
      csr_op_o     = dbg_we_i ? CSR_OP_WRITE : CSR_OP_NONE;
      core_stall_o = core_csr_access_i;
      w_wait_nxt   = '0;
      w_state_nxt  = ST_RESP;
    end else if (!dbg_req_i) begin
      w_wait_nxt = '0;
    end else if ((core_csr_access_i || exc_busy_i) && !w_wait_sat) begin
      w_wait_nxt = r_wait_cnt + WAIT_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_rvalid   <= w_gnt;
      if (w_gnt) begin
        r_rdata <= csr_rdata_i;
      end
    end
  end

  assign core_csr_rdata_o = csr_rdata_i;
  assign dbg_gnt_o        = w_gnt;
  assign dbg_rvalid_o     = r_rvalid;
  assign dbg_rdata_o      = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_riscv_csr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_riscv_csr_arbiter: directed self-checking bench               |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module tb_riscv_csr_arbiter;
  import riscv_defines::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_csr_access_i;
  logic [11:0] core_csr_addr_i;
  logic [31:0] core_csr_wdata_i;
  logic [1:0]  core_csr_op_i;
  logic [31:0] core_csr_rdata_o;
  logic        core_stall_o;
  logic        dbg_req_i;
  logic        dbg_we_i;
  logic [11:0] dbg_addr_i;
  logic [31:0] dbg_wdata_i;
  logic        dbg_halted_i;
  logic        exc_busy_i;
  logic        dbg_gnt_o;
  logic        dbg_rvalid_o;
  logic [31:0] dbg_rdata_o;
  logic        csr_access_o;
  logic [11:0] csr_addr_o;
  logic [31:0] csr_wdata_o;
  logic [1:0]  csr_op_o;
  logic [31:0] csr_rdata_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_csr_arbiter u_dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .core_csr_access_i (core_csr_access_i),
    .core_csr_addr_i   (core_csr_addr_i),
    .core_csr_wdata_i  (core_csr_wdata_i),
    .core_csr_op_i     (core_csr_op_i),
    .core_csr_rdata_o  (core_csr_rdata_o),
    .core_stall_o      (core_stall_o),
    .dbg_req_i         (dbg_req_i),
    .dbg_we_i          (dbg_we_i),
    .dbg_addr_i        (dbg_addr_i),
    .dbg_wdata_i       (dbg_wdata_i),
    .dbg_halted_i      (dbg_halted_i),
    .exc_busy_i        (exc_busy_i),
    .dbg_gnt_o         (dbg_gnt_o),
    .dbg_rvalid_o      (dbg_rvalid_o),
    .dbg_rdata_o       (dbg_rdata_o),
    .csr_access_o      (csr_access_o),
    .csr_addr_o        (csr_addr_o),
    .csr_wdata_o       (csr_wdata_o),
    .csr_op_o          (csr_op_o),
    .csr_rdata_i       (csr_rdata_i)
  );

  // Minimal CSR file: mstatus (0x300), mepc (0x341), custom 0x7C0
  logic [31:0] m_mstatus, m_mepc, m_c7c0;

  function automatic logic [31:0] csr_apply(input logic [1:0] op, input logic [31:0] old,
                                            input logic [31:0] wd);
    case (op)
      CSR_OP_WRITE: csr_apply = wd;
      CSR_OP_SET:   csr_apply = old | wd;
      CSR_OP_CLEAR: csr_apply = old & ~wd;
      default:      csr_apply = old;
    endcase
  endfunction

  always_comb begin
    case (csr_addr_o)
      12'h300: csr_rdata_i = m_mstatus;
      12'h341: csr_rdata_i = m_mepc;
      12'h7C0: csr_rdata_i = m_c7c0;
      default: csr_rdata_i = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mstatus <= '0;
      m_mepc    <= '0;
      m_c7c0    <= '0;
    end else if (csr_access_o) begin
      case (csr_addr_o)
        12'h300: m_mstatus <= csr_apply(csr_op_o, m_mstatus, csr_wdata_o);
        12'h341: m_mepc    <= csr_apply(csr_op_o, m_mepc, csr_wdata_o);
        12'h7C0: m_c7c0    <= csr_apply(csr_op_o, m_c7c0, csr_wdata_o);
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic core_drive(input logic acc, input logic [1:0] op, input logic [11:0] addr,
                            input logic [31:0] wd);
    core_csr_access_i = acc;
    core_csr_op_i     = op;
    core_csr_addr_i   = addr;
    core_csr_wdata_i  = wd;
  endtask

  task automatic dbg_drive(input logic req, input logic we, input logic [11:0] addr,
                           input logic [31:0] wd);
    dbg_req_i   = req;
    dbg_we_i    = we;
    dbg_addr_i  = addr;
    dbg_wdata_i = wd;
  endtask

  initial begin
    rst_n        = 1'b0;
    dbg_halted_i = 1'b0;
    exc_busy_i   = 1'b0;
    core_drive(1'b0, CSR_OP_NONE, 12'h0, 32'h0);
    dbg_drive(1'b0, 1'b0, 12'h0, 32'h0);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_rvalid", 32'(dbg_rvalid_o), 32'h0);
    chk("rst_rdata", dbg_rdata_o, 32'h0);
    chk("rst_access", 32'(csr_access_o), 32'h0);
    chk("rst_gnt", 32'(dbg_gnt_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Core write of mepc, passes straight through
    @(negedge clk);
    core_drive(1'b1, CSR_OP_WRITE, 12'h341, 32'h1234);
    #1;
    chk("core_wr_op", 32'(csr_op_o), 32'(CSR_OP_WRITE));
    chk("core_wr_addr", 32'(csr_addr_o), 32'h341);
    chk("core_wr_wdata", csr_wdata_o, 32'h1234);

    // Core-only SET of mstatus
    @(negedge clk);
    core_drive(1'b1, CSR_OP_SET, 12'h300, 32'h1);
    #1;
    chk("core_set_op", 32'(csr_op_o), 32'(CSR_OP_SET));
    chk("core_set_addr", 32'(csr_addr_o), 32'h300);
    chk("core_set_access", 32'(csr_access_o), 32'h1);
    chk("core_set_stall", 32'(core_stall_o), 32'h0);
    chk("core_set_rdata", core_csr_rdata_o, 32'h0);

    // Idle core presenting WRITE must not reach the CSR file
    @(negedge clk);
    core_drive(1'b0, CSR_OP_WRITE, 12'h300, 32'hFFFF_FFFF);
    #1;
    chk("idle_op_forced", 32'(csr_op_o), 32'(CSR_OP_NONE));
    chk("idle_access", 32'(csr_access_o), 32'h0);
    chk("idle_core_rdata", core_csr_rdata_o, 32'h1);

    // Idle debug read of mepc
    @(negedge clk);
    core_drive(1'b0, CSR_OP_NONE, 12'h0, 32'h0);
    dbg_drive(1'b1, 1'b0, 12'h341, 32'h0);
    #1;
    chk("rd_gnt", 32'(dbg_gnt_o), 32'h1);
    chk("rd_access", 32'(csr_access_o), 32'h1);
    chk("rd_addr", 32'(csr_addr_o), 32'h341);
    chk("rd_op", 32'(csr_op_o), 32'(CSR_OP_NONE));
    chk("rd_stall", 32'(core_stall_o), 32'h0);
    @(negedge clk);
    #1;
    chk("rd_rvalid", 32'(dbg_rvalid_o), 32'h1);
    chk("rd_rdata", dbg_rdata_o, 32'h1234);
    chk("rd_resp_no_gnt", 32'(dbg_gnt_o), 32'h0);
    @(negedge clk);
    dbg_drive(1'b0, 1'b0, 12'h0, 32'h0);
    #1;
    chk("rd_rvalid_t2", 32'(dbg_rvalid_o), 32'h0);

    // Starvation: grant only on the 9th request cycle
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      core_drive(1'b1, CSR_OP_SET, 12'h300, 32'h0);
      dbg_drive(1'b1, 1'b1, 12'h7C0, 32'h1);
      #1;
      chk($sformatf("starve_gnt_%0d", i), 32'(dbg_gnt_o), (i == 9) ? 32'h1 : 32'h0);
      chk($sformatf("starve_stall_%0d", i), 32'(core_stall_o), (i == 9) ? 32'h1 : 32'h0);
    end
    chk("starve_op", 32'(csr_op_o), 32'(CSR_OP_WRITE));
    chk("starve_addr", 32'(csr_addr_o), 32'h7C0);
    @(negedge clk);
    dbg_drive(1'b0, 1'b0, 12'h0, 32'h0);
    #1;
    chk("starve_rvalid", 32'(dbg_rvalid_o), 32'h1);
    chk("starve_rdata_pre", dbg_rdata_o, 32'h0);
    chk("starve_stall_after", 32'(core_stall_o), 32'h0);
    chk("starve_core_addr", 32'(csr_addr_o), 32'h300);

    // Read back 0x7C0
    @(negedge clk);
    core_drive(1'b0, CSR_OP_NONE, 12'h0, 32'h0);
    dbg_drive(1'b1, 1'b0, 12'h7C0, 32'h0);
    #1;
    chk("rb_gnt", 32'(dbg_gnt_o), 32'h1);
    @(negedge clk);
    dbg_drive(1'b0, 1'b0, 12'h0, 32'h0);
    #1;
    chk("rb_rdata", dbg_rdata_o, 32'h1);

    // Halted: debug wins immediately over core traffic
    @(negedge clk);
    dbg_halted_i = 1'b1;
    core_drive(1'b1, CSR_OP_SET, 12'h300, 32'h0);
    dbg_drive(1'b1, 1'b0, 12'h300, 32'h0);
    #1;
    chk("halt_gnt", 32'(dbg_gnt_o), 32'h1);
    chk("halt_stall", 32'(core_stall_o), 32'h1);
    @(negedge clk);
    dbg_halted_i = 1'b0;
    core_drive(1'b0, CSR_OP_NONE, 12'h0, 32'h0);
    dbg_drive(1'b0, 1'b0, 12'h0, 32'h0);
    #1;
    chk("halt_rvalid", 32'(dbg_rvalid_o), 32'h1);
    chk("halt_rdata", dbg_rdata_o, 32'h1);

    // Exception window holds off a saturated request
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      exc_busy_i = 1'b1;
      core_drive(1'b1, CSR_OP_SET, 12'h300, 32'h0);
      dbg_drive(1'b1, 1'b0, 12'h341, 32'h0);
      #1;
      chk($sformatf("exc_gnt_%0d", i), 32'(dbg_gnt_o), 32'h0);
    end
    @(negedge clk);
    exc_busy_i = 1'b0;
    #1;
    chk("exc_release_gnt", 32'(dbg_gnt_o), 32'h1);
    chk("exc_release_stall", 32'(core_stall_o), 32'h1);
    @(negedge clk);
    core_drive(1'b0, CSR_OP_NONE, 12'h0, 32'h0);
    dbg_drive(1'b0, 1'b0, 12'h0, 32'h0);
    #1;
    chk("exc_rdata", dbg_rdata_o, 32'h1234);

    // Reset asserted during RESP drops the response
    @(negedge clk);
    dbg_drive(1'b1, 1'b0, 12'h341, 32'h0);
    #1;
    chk("rstr_gnt", 32'(dbg_gnt_o), 32'h1);
    @(negedge clk);
    dbg_drive(1'b0, 1'b0, 12'h0, 32'h0);
    #1;
    chk("rstr_rvalid_pre", 32'(dbg_rvalid_o), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rstr_rvalid_async", 32'(dbg_rvalid_o), 32'h0);
    chk("rstr_rdata_async", dbg_rdata_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstr_rvalid_rel", 32'(dbg_rvalid_o), 32'h0);
    @(negedge clk);
    #1;
    chk("rstr_rvalid_after", 32'(dbg_rvalid_o), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
